jtag_seq_master: RTL

//   Synthesizable JTAG master: turns shift commands into TCK/TMS/TDI waveforms and

---
 rtl/jtag_seq_master.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/jtag_seq_master.sv
// JTAG pin sequencer: converts TAP reset / IR / DR / idle commands into TCK/TMS/TDI
// slots, captures TDO during shift slots and returns it right-aligned.
module jtag_seq_master #(
  parameter int ClkDiv = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [1:0]  cmd_op_i,
  input  logic [5:0]  cmd_len_i,
  input  logic [31:0] cmd_data_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_data_o,
  output logic        busy_o,
  output logic        jtag_tck_o,
  output logic        jtag_tms_o,
  output logic        jtag_tdi_o,
  input  logic        jtag_tdo_i,
  output logic        jtag_trst_no
);

  typedef enum logic [2:0] {IDLE, PRE, SHIFT, POST, RESP} state_e;

  localparam int DivW = (ClkDiv > 1) ? $clog2(ClkDiv) : 1;
  localparam logic [DivW-1:0] DivMax = DivW'(ClkDiv - 1);

  localparam logic [1:0] OpReset = 2'd0;
  localparam logic [1:0] OpIr    = 2'd1;
  localparam logic [1:0] OpDr    = 2'd2;

  state_e            state_q;
  logic [1:0]        op_q;
  logic [5:0]        len_q;
  logic [31:0]       data_q;
  logic [31:0]       cap_q;
  logic [5:0]        cnt_q;
  logic [DivW-1:0]   div_q;
  logic              tck_q, tms_q, tdi_q, trst_q, rsp_valid_q;

  function automatic logic [5:0] eff_len(input logic [5:0] l);
    if (l == 6'd0)       return 6'd1;
    else if (l > 6'd32)  return 6'd32;
    else                 return l;
  endfunction

  // Slots before SHIFT (or the whole sequence for TAP_RESET / IDLE_CYCLES).
  function automatic logic [5:0] pre_slots(input logic [1:0] op, input logic [5:0] l);
    case (op)
      OpReset: return 6'd6;
      OpIr:    return 6'd4;
      OpDr:    return 6'd3;
      default: return l;
    endcase
  endfunction

  function automatic logic pre_tms(input logic [1:0] op, input logic [5:0] c);
    case (op)
      OpReset: return c < 6'd5;
      OpIr:    return c < 6'd2;
      OpDr:    return c == 6'd0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic pre_trst_n(input logic [1:0] op, input logic [5:0] c);
    return !(op == OpReset && c < 6'd5);
  endfunction

  assign cmd_ready_o  = rst_ni && (state_q == IDLE);
  assign busy_o       = (state_q != IDLE);
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_data_o   = cap_q;
  assign jtag_tck_o   = tck_q;
  assign jtag_tms_o   = tms_q;
  assign jtag_tdi_o   = tdi_q;
  assign jtag_trst_no = trst_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      op_q        <= 2'd0;
      len_q       <= 6'd0;
      data_q      <= 32'd0;
      cap_q       <= 32'd0;
      cnt_q       <= 6'd0;
      div_q       <= '0;
      tck_q       <= 1'b0;
      tms_q       <= 1'b1;
      tdi_q       <= 1'b0;
      trst_q      <= 1'b1;
      rsp_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid_i) begin
            op_q    <= cmd_op_i;
            len_q   <= eff_len(cmd_len_i);
            data_q  <= cmd_data_i;
            cap_q   <= 32'd0;
            cnt_q   <= 6'd0;
            div_q   <= '0;
            tck_q   <= 1'b0;
            tms_q   <= pre_tms(cmd_op_i, 6'd0);
            trst_q  <= pre_trst_n(cmd_op_i, 6'd0);
            tdi_q   <= 1'b0;
            state_q <= PRE;
          end
        end
        PRE, SHIFT, POST: begin
          if (div_q != DivMax) begin
            div_q <= div_q + 1'b1;
          end else if (!tck_q) begin
            // Rising TCK edge: TDO is sampled on the same clk edge.
            div_q <= '0;
            tck_q <= 1'b1;
            if (state_q == SHIFT) cap_q[cnt_q[4:0]] <= jtag_tdo_i;
          end else begin
            // Slot end: drop TCK and present the next slot's TMS/TDI.
            div_q <= '0;
            tck_q <= 1'b0;
            case (state_q)
              PRE: begin
                if (cnt_q == pre_slots(op_q, len_q) - 6'd1) begin
                  cnt_q  <= 6'd0;
                  trst_q <= 1'b1;
                  if (op_q == OpIr || op_q == OpDr) begin
                    state_q <= SHIFT;
                    tms_q   <= (len_q == 6'd1);
                    tdi_q   <= data_q[0];
                  end else begin
                    state_q     <= RESP;
                    rsp_valid_q <= 1'b1;
                    tms_q       <= 1'b0;
                    tdi_q       <= 1'b0;
                  end
                end else begin
                  cnt_q  <= cnt_q + 6'd1;
                  tms_q  <= pre_tms(op_q, cnt_q + 6'd1);
                  trst_q <= pre_trst_n(op_q, cnt_q + 6'd1);
                end
              end
              SHIFT: begin
                if (cnt_q == len_q - 6'd1) begin
                  state_q <= POST;
                  cnt_q   <= 6'd0;
                  tms_q   <= 1'b1;
                  tdi_q   <= 1'b0;
                end else begin
                  cnt_q <= cnt_q + 6'd1;
                  tms_q <= (cnt_q + 6'd2 == len_q);
                  tdi_q <= data_q[cnt_q[4:0] + 5'd1];
                end
              end
              default: begin
                tms_q <= 1'b0;
                if (cnt_q == 6'd1) begin
                  state_q     <= RESP;
                  rsp_valid_q <= 1'b1;
                end else begin
                  cnt_q <= 6'd1;
                end
              end
            endcase
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
